// File: rtl/segment_pkg.sv
// Shared seven-segment code table and decoder FSM state type, used by both the
// display decoder and any display encoder driving the same buses.
package segment_pkg;

  // Active-high segment codes, bit 0 = segment a ... bit 6 = segment g.
  localparam logic [6:0] SEG_CODES [16] = '{
    7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
    7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71
  };

  typedef enum logic [1:0] {
    ST_BLANK,
    ST_SETTLE,
    ST_LOCKED,
    ST_FAULT
  } state_t;

  function automatic logic [6:0] seg7_encode(input logic [3:0] digit);
    return SEG_CODES[digit];
  endfunction

endpackage

// File: rtl/seg7_digit_decode.sv
// Combinational seven-segment to decimal digit decoder; only codes for 0..9
// are legal, hex letters and partial patterns are rejected.
module seg7_digit_decode
  import segment_pkg::*;
(
  input  logic [6:0] seg_in,
  output logic [3:0] digit_out,
  output logic       legal_out
);

  always_comb begin
    // NOTE: every output gets a default before the search loop so no latch is inferred.
    digit_out = 4'd0;
    legal_out = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (seg_in == SEG_CODES[i]) begin
        digit_out = 4'(i);
        legal_out = 1'b1;
      end
    end
  end

endmodule

// File: rtl/segment_led_decoder.sv
// Recovers a 0..255 count from two multiplexed seven-segment displays, accepting
// a value only after it has been held steady for STABLE_CYCLES samples.
module segment_led_decoder
  import segment_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [8:0] segment_led_1,
  input  logic [8:0] segment_led_2,
  output logic [7:0] count_out,
  output logic       valid_out,
  output logic       error_out,
  output logic       update_out
);

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

  logic [17:0] w_sample;
  logic [17:0] r_s;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_next;
  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_count;
  logic        r_update;
  logic        r_first;

  logic        w_change;
  logic        w_blank;
  logic        w_reached;
  logic [3:0]  w_tens;
  logic [3:0]  w_ones;
  logic        w_tens_ok;
  logic        w_ones_ok;
  logic [1:0]  w_hund;
  logic        w_dots_ok;
  logic [8:0]  w_value;
  logic        w_legal;
  logic        w_load;

  // r_s holds the previous sample; the live bus is compared against it so a
  // steady input locks STABLE_CYCLES+1 edges after it appears.
  assign w_sample  = {segment_led_1, segment_led_2};
  assign w_change  = (w_sample != r_s);
  assign w_blank   = r_s[17] | r_s[8];
  assign w_reached = (w_cnt_next == STABLE_MAX);

  always_comb begin
    if (w_change)                 w_cnt_next = 8'd0;
    else if (r_cnt == STABLE_MAX) w_cnt_next = r_cnt;
    else                          w_cnt_next = r_cnt + 8'd1;
  end

  seg7_digit_decode u_tens (
    .seg_in    (r_s[15:9]),
    .digit_out (w_tens),
    .legal_out (w_tens_ok)
  );

  seg7_digit_decode u_ones (
    .seg_in    (r_s[6:0]),
    .digit_out (w_ones),
    .legal_out (w_ones_ok)
  );

  // Dots encode hundreds: ones-dot alone = 1, both = 2, tens-dot alone is invalid.
  always_comb begin
    w_hund    = 2'd0;
    w_dots_ok = 1'b1;
    case ({r_s[16], r_s[7]})
      2'b00:   w_hund = 2'd0;
      2'b01:   w_hund = 2'd1;
      2'b11:   w_hund = 2'd2;
      default: w_dots_ok = 1'b0;
    endcase
  end

  assign w_value = 9'(w_hund) * 9'd100 + 9'(w_tens) * 9'd10 + 9'(w_ones);
  assign w_legal = w_tens_ok & w_ones_ok & w_dots_ok & (w_value <= 9'd255);

  always_comb begin
    w_state_next = r_state;
    if (w_blank) begin
      w_state_next = ST_BLANK;
    end else begin
      case (r_state)
        ST_BLANK:  w_state_next = ST_SETTLE;
        ST_SETTLE: if (w_reached) w_state_next = w_legal ? ST_LOCKED : ST_FAULT;
        ST_LOCKED,
        ST_FAULT:  if (w_change) w_state_next = ST_SETTLE;
        default:   w_state_next = ST_BLANK;
      endcase
    end
  end

  assign w_load = (r_state == ST_SETTLE) && (w_state_next == ST_LOCKED);

  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (rst_in) begin
      r_state  <= ST_BLANK;
      r_s      <= '0;
      r_cnt    <= '0;
      r_count  <= '0;
      r_update <= 1'b0;
      r_first  <= 1'b1;
    end else begin
      r_state  <= w_state_next;
      r_s      <= w_sample;
      r_cnt    <= w_cnt_next;
      r_update <= w_load && (r_first || (w_value[7:0] != r_count));
      if (w_load) begin
        r_count <= w_value[7:0];
        r_first <= 1'b0;
      end else if (w_state_next == ST_BLANK) begin
        r_first <= 1'b1;
      end
    end
  end

  assign count_out  = r_count;
  assign valid_out  = (r_state == ST_LOCKED);
  assign error_out  = (r_state == ST_FAULT);
  assign update_out = r_update;

endmodule

// File: doc/segment_led_decoder.md
SEGMENT_LED_DECODER -- requirements
Module: segment_led_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, range 1..255: consecutive identical samples required before a display value is accepted.
REQ-002 SHALL have port clk_in  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port rst_in  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port segment_led_1  input  9  tens display: [6:0] segments a..g, [7] dot (hundreds>=2), [8] blank/reset indicator.
REQ-005 SHALL have port segment_led_2  input  9  ones display: [6:0] segments a..g, [7] dot (hundreds>=1), [8] blank/reset indicator.
REQ-006 SHALL have port count_out  output  8  last accepted decoded count.
REQ-007 SHALL have port valid_out  output  1  high while in LOCKED.
REQ-008 SHALL have port error_out  output  1  high while in FAULT.
REQ-009 SHALL have port update_out  output  1  one-cycle pulse when count_out is loaded with a value different from the previous one, or on the first lock after BLANK or reset.

Function
REQ-010 SHALL register both display buses once (sample register S) and compare S with its previous value (P) every cycle.
REQ-011 SHALL clear the 8-bit stable counter when S != P, and otherwise increment it, saturating at STABLE_CYCLES.
REQ-012 SHALL decode the segment field [6:0] only as the decimal codes 3f,06,5b,4f,66,6d,7d,07,7f,6f (digits 0..9); every other pattern is illegal.
REQ-013 SHALL decode the hundreds digit from the dots as follows: seg2[7]=0,seg1[7]=0 -> 0; seg2[7]=1,seg1[7]=0 -> 1; both set -> 2; seg1[7]=1 with seg2[7]=0 -> illegal.
REQ-014 SHALL compute the value 100*h + 10*tens + ones in 9-bit arithmetic; a value >255 is illegal.
REQ-015 SHALL implement the FSM states BLANK, SETTLE, LOCKED and FAULT.
REQ-016 SHALL force BLANK from any state, on the next edge, whenever S has bit [8] set on either bus; BLANK has priority over all other transitions.
REQ-017 SHALL leave BLANK for SETTLE when neither blank bit is set in S.
REQ-018 SHALL, in SETTLE, go to LOCKED when the stable counter reaches STABLE_CYCLES and the pattern is legal, or to FAULT when it reaches STABLE_CYCLES and the pattern is illegal.
REQ-019 SHALL leave LOCKED or FAULT for SETTLE on any S != P.
REQ-020 SHALL load count_out on the SETTLE->LOCKED edge and hold it through SETTLE, FAULT and BLANK.
REQ-021 SHALL assert valid_out and error_out as registered state decodes, never simultaneously.
REQ-022 SHALL give a latency of STABLE_CYCLES+1 rising edges from input bus steady to valid_out/error_out/update_out asserted, with the default value giving 5 edges.
REQ-023 SHALL never lock on an input that changes more often than every STABLE_CYCLES+1 cycles.

Reset
REQ-024 SHALL, while rst_in=1 at an edge, set the state to BLANK, count_out=0, valid_out=0, error_out=0, update_out=0, the stable counter to 0, and S and P to 0.
REQ-025 SHALL, on reset mid-SETTLE or mid-LOCKED, discard the in-progress settle and make the first lock after reset pulse update_out regardless of value.

Structure
REQ-026 SHALL take the seven-segment code constants (digits 0..F) and the FSM state enum from shared package segment_pkg, used by the display encoder as well.
REQ-027 SHALL contain exactly one combinational sub-module, seg7_digit_decode, which maps [6:0] to a 4-bit digit plus a legal flag and is instantiated twice.

Verification
REQ-028 SHALL test reset as follows: rst_in=1 for 3 cycles with arbitrary inputs -> count_out=0, valid_out=0, error_out=0, update_out=0.
REQ-029 SHALL test a basic lock as follows: seg1=9'h05B, seg2=9'h0CF held -> 5 edges later count_out=123, valid_out=1, single update_out pulse; the same value re-locked after a glitch -> no pulse.
REQ-030 SHALL test the range boundary as follows: seg1=9'h0ED, seg2=9'h0ED -> count_out=255 locked; then seg1=9'h0FD, seg2=9'h0BF (260) -> valid_out=0, error_out=1 after 5 edges, count_out stays 255.
REQ-031 SHALL test glitch rejection as follows: seg2 toggling 9'h03F/9'h006 every 3 cycles for 30 cycles -> valid_out stays 0, no update_out.
REQ-032 SHALL test blanking as follows: LOCKED at 42, then seg1[8]=1 -> valid_out=0 by the second edge, count_out holds 42; seg1[8]=0 with 42 still applied -> relock with update_out pulse.
REQ-033 SHALL test an illegal pattern as follows: seg2[6:0]=7'h00, or seg1[7]=1 with seg2[7]=0 -> FAULT, error_out=1, valid_out=0.
